// File: rtl/uart_tx.sv
// UART transmit serializer: a one-entry holding register feeds a shift register
// that sends start, LSB-first data, optional parity and stop bits, one bit per baud_tick.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state_reg, state_next;
    logic                 tx_reg, tx_next;
    logic                 busy_reg, busy_next;
    logic                 frame_done_reg, frame_done_next;
    logic                 hold_full_reg, hold_full_next;
    logic [DATA_BITS-1:0] hold_data_reg, hold_data_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic [2:0]           bit_cnt_reg, bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;

    logic                 accept;
    logic                 launch;
    logic                 hold_parity;

    // Parity is precomputed from the holding register so it is ready at launch;
    // seeding the chain with 1 yields odd parity, 0 yields even.
    logic [DATA_BITS:0]   par_chain;
    assign par_chain[0] = (PARITY == 1);
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_parity
            assign par_chain[gi+1] = par_chain[gi] ^ hold_data_reg[gi];
        end
    endgenerate
    assign hold_parity = par_chain[DATA_BITS];

    assign accept = in_valid && !hold_full_reg;

    always_comb begin
        state_next      = state_reg;
        tx_next         = tx_reg;
        busy_next       = busy_reg;
        frame_done_next = 1'b0;
        hold_full_next  = hold_full_reg;
        hold_data_next  = hold_data_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        bit_cnt_next    = bit_cnt_reg;
        stop_cnt_next   = stop_cnt_reg;
        launch          = 1'b0;

        if (accept) begin
            hold_full_next = 1'b1;
            hold_data_next = in_data;
        end

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (baud_tick && hold_full_reg) begin
                    launch = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_next      = shift_reg[0];
                    bit_cnt_next = 3'd0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        stop_cnt_next = 1'b0;
                        if (PARITY != 0) begin
                            tx_next    = parity_reg;
                            state_next = PAR;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
            PAR: begin
                if (baud_tick) begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_reg == STOP_LAST) begin
                        frame_done_next = 1'b1;
                        // A queued byte starts immediately so frames run back to back.
                        if (hold_full_reg) begin
                            launch = 1'b1;
                        end else begin
                            busy_next  = 1'b0;
                            state_next = IDLE;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase

        // Launch only happens with the holding register full, so it never
        // coincides with an accept.
        if (launch) begin
            shift_next     = hold_data_reg;
            parity_next    = hold_parity;
            hold_full_next = 1'b0;
            tx_next        = 1'b0;
            busy_next      = 1'b1;
            bit_cnt_next   = 3'd0;
            state_next     = START;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            hold_full_reg  <= 1'b0;
            hold_data_reg  <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            bit_cnt_reg    <= 3'd0;
            stop_cnt_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tx_reg         <= tx_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
            hold_full_reg  <= hold_full_next;
            hold_data_reg  <= hold_data_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            bit_cnt_reg    <= bit_cnt_next;
            stop_cnt_reg   <= stop_cnt_next;
        end
    end

    assign in_ready   = !hold_full_reg;
    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer that directly consumes the single-cycle baud_tick pulse from the baud rate generator. It accepts parallel bytes over a valid/ready handshake into a one-entry holding register. Each byte is shifted out LSB-first on the serial line as start, data, optional parity and stop bits, with every bit lasting exactly one baud_tick period. It sits between the host-side write logic and the tx pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
baud_tick  input  1  one-clk-wide pulse, once per bit period, from the baud rate generator
in_data  input  DATA_BITS  byte to transmit; sampled when in_valid && in_ready
in_valid  input  1  in_data is valid
in_ready  output  1  holding register is empty and can accept a byte
tx  output  1  serial line; idle level is high
busy  output  1  a frame is on the line
frame_done  output  1  one-clk pulse when the last stop bit completes

Behaviour:
- Reset values, sampled on the clk edge where reset=1: tx=1, busy=0, frame_done=0, in_ready=1, holding register empty, state IDLE, bit counter 0.
- Reset mid-frame aborts the frame. tx returns to 1 on that edge, the pending byte is discarded, and no frame_done pulse is produced.
- Handshake:
  - in_ready = holding register empty. It is driven from a register, with no combinational path from in_valid.
  - A transfer occurs on any clk edge with in_valid && in_ready. The holding register becomes full and in_ready drops on the next cycle.
  - Accepting a byte never requires baud_tick.
- Holding-to-shift transfer happens only on a baud_tick edge that launches a start bit. The holding register empties on that edge and in_ready returns to 1 on the next cycle. While the register is full, in_ready=0, so accept and transfer never occur on the same edge.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START. All transitions, and all tx changes, happen only on edges where baud_tick=1.
  - IDLE: tx=1. On baud_tick with the holding register full: load the shift register, tx<=0, busy<=1, go to START.
  - START: on baud_tick: tx<=data[0], bit counter<=0, go to DATA.
  - DATA: on each baud_tick, counter+1. tx<=next data bit, LSB first.
    - After bit DATA_BITS-1 completes: if PARITY!=0, tx<=parity bit and go to PARITY.
    - Otherwise tx<=1 and go to STOP.
  - PARITY: the parity bit is the XOR of the DATA_BITS data bits for even parity, and its inverse for odd parity. On baud_tick: tx<=1, go to STOP.
  - STOP: holds tx=1 for STOP_BITS tick periods. On the tick that ends the last stop bit, frame_done<=1 for exactly one cycle.
    - If the holding register is full on that same edge: tx<=0, load the next byte, go to START. busy stays 1, giving back-to-back frames with no idle gap.
    - Otherwise busy<=0 and go to IDLE.
- Latency: a byte accepted while IDLE drives the start bit on the first baud_tick edge after acceptance. The launch edge is never the accept edge itself.
- Frame length is exactly 1 + DATA_BITS + (PARITY?1:0) + STOP_BITS tick periods.
- in_valid while in_ready=0 is ignored, and in_data is not sampled.
- baud_tick asserted in consecutive cycles is legal; each asserted cycle advances one bit.
- Counter width is 3 bits. No wrap-around beyond DATA_BITS-1.

Test Plan:
1. Tie baud_tick high every 4th clk; default params; send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1 with each bit exactly 4 clks; busy high for 40 clks; one frame_done pulse.
2. PARITY=2, send 0x07 (three ones) -> parity bit 1; PARITY=1, same byte -> parity bit 0; frame is 11 bit periods.
3. Hold in_valid high with 0xA5 then 0x3C queued -> second byte is accepted while the first is shifting; its start bit follows the first byte's stop bit with no idle period; busy never drops between frames; two frame_done pulses.
4. STOP_BITS=2, DATA_BITS=5, send 0x1F -> data bits 1,1,1,1,1, then tx high for 2 tick periods before busy=0.
5. Assert reset for 1 clk during data bit 3 of 0xF0 with a byte pending -> tx=1, busy=0, in_ready=1 next cycle; no frame_done; the pending byte is never transmitted.
6. in_valid pulsed 3 clks before a baud_tick while IDLE -> start bit appears on that tick edge; in_ready is low for exactly the cycles between accept and launch.
